tdm_stream_demux: RTL and testbench
===================================

# tdm_stream_demux

Receive-side counterpart of the three-source mode multiplexer. Samples a single multiplexed byte stream once per programmable dwell period. Uses the accompanying 3-bit mode tag to route each sample back into one of three per-channel holding registers, and issues a one-cycle strobe for each update. Also flags channels that have not been refreshed recently and counts samples that carry illegal mode tags.

## Interface
Parameters:
- DATA_W, 8, width of the stream and of each channel register
- STALE_LIMIT, 15, number of sample ticks without an update before a channel is flagged stale; legal range 1..255

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  sampling enable; when low, the dwell counter holds and no ticks occur
- dwell  in  3  sample period in cycles; values 0 and 1 both mean sample every cycle
- mode  in  3  channel tag of the current din: 000→ch0, 001→ch1, 010→ch2, others illegal
- din  in  DATA_W  multiplexed data stream
- ch0_out, ch1_out, ch2_out  out  DATA_W  last byte routed to each channel
- ch_strobe  out  3  one-hot, one-cycle pulse; bit i marks that chi_out was updated
- sample_tick  out  1  one-cycle pulse on every sample, including illegal ones
- ch_stale  out  3  bit i high while channel i has gone STALE_LIMIT ticks without an update
- err_count  out  8  saturating count of illegal-tag samples

## Operation
- Period P = max(dwell, 1). The 3-bit counter cnt counts cycles while en=1.
- Internal tick = en && (cnt >= P-1). On a tick, cnt clears to 0; otherwise, when en=1, cnt increments. When en=0, cnt holds.
- The ">=" compare is mandatory. If dwell is lowered below the current cnt, the next enabled cycle ticks; there is no 8-cycle wrap.
- On a tick with mode 000/001/010:
  - the matching chi_out loads din;
  - the matching ch_strobe bit is set;
  - the matching stale counter clears to 0.
- On a tick with any other mode:
  - no channel register changes;
  - ch_strobe = 000;
  - err_count increments, saturating at 255 (no wrap).
- Stale counters: one per channel, 8 bits. On each tick where channel i is not updated, counter i increments, saturating at STALE_LIMIT. ch_stale[i] = (counter i == STALE_LIMIT).
- Non-tick cycles: ch_strobe = 000 and sample_tick = 0. Channel registers, stale counters and err_count hold.
- Reset values:
  - cnt = 0;
  - ch0/1/2_out = 0;
  - ch_strobe = 000; sample_tick = 0;
  - err_count = 0;
  - all stale counters = STALE_LIMIT, so ch_stale = 111 until each channel's first update.
- Reset asserted mid-operation immediately forces all of the above, regardless of en or an in-progress count. Counting restarts from cnt = 0 after release.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- din and mode are sampled at the rising edge on which tick is true. chi_out, ch_strobe, sample_tick and ch_stale reflect that sample in the following cycle (latency 1).
- With en held high and constant dwell = P ≥ 1, ticks occur every P cycles. The first tick after reset release comes on the P-th enabled edge.
- A change to dwell takes effect on the next compare. A change to mode or din is only observed at tick edges.
- ch_strobe and sample_tick are never high for two consecutive cycles unless P = 1.
- ch_stale[i] drops in the same cycle that ch_strobe[i] pulses. It rises in the cycle after the STALE_LIMIT-th consecutive non-updating tick.

## Test plan
- Reset check: assert rst mid-count with en=1 → next cycle:
  - all chi_out = 0x00;
  - ch_strobe = 000; sample_tick = 0;
  - err_count = 0; ch_stale = 111.
- Round-robin: dwell = 4, en = 1, mode cycles 000/001/010 with din = 0xA1/0xB2/0xC3 held for each 4-cycle window → ch0/1/2_out = A1/B2/C3. ch_strobe pulses 001, 010, 100 every 4 cycles; ch_stale goes to 000 after all three have been updated.
- Illegal tags: dwell = 1, mode = 111 for 300 cycles → err_count climbs to 255 and holds; channel outputs are unchanged; sample_tick pulses every cycle; ch_strobe stays 000.
- Stale detection: dwell = 2, default STALE_LIMIT; update ch0 once, then send only ch1 for 15 ticks → ch_stale[0] rises in the cycle after the 15th tick; one ch0 sample clears it with a simultaneous ch_strobe[0] pulse.
- Enable/pause: dwell = 5; drop en after 3 cycles for 10 cycles → no ticks during the pause; the tick occurs 2 enabled cycles after en returns.
- Dwell shrink: dwell = 7, cnt reaches 5, dwell is switched to 2 → tick on the next edge, then a tick every 2 cycles thereafter.

Source files
------------

// File: rtl/tdm_stream_demux_if.sv
// Bundles the sampling controls, the multiplexed stream and the per-channel
// results. The stream source side uses "master" and the demux uses "slave".
interface tdm_stream_demux_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic [2:0]        dwell;
    logic [2:0]        mode;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] ch0_out;
    logic [DATA_W-1:0] ch1_out;
    logic [DATA_W-1:0] ch2_out;
    logic [2:0]        ch_strobe;
    logic              sample_tick;
    logic [2:0]        ch_stale;
    logic [7:0]        err_count;

    modport master (
        output en, dwell, mode, din,
        input  ch0_out, ch1_out, ch2_out, ch_strobe, sample_tick, ch_stale, err_count
    );

    modport slave (
        input  en, dwell, mode, din,
        output ch0_out, ch1_out, ch2_out, ch_strobe, sample_tick, ch_stale, err_count
    );
endinterface

// File: rtl/tdm_stream_demux.sv
// Receive-side demux for a three-source TDM byte stream. Samples the stream
// once per dwell period, routes each sample by its mode tag into one of three
// holding registers, tracks staleness per channel and counts illegal tags.
module tdm_stream_demux #(
    parameter int DATA_W      = 8,
    parameter int STALE_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    tdm_stream_demux_if.slave  bus
);
    localparam logic [7:0] LIMIT = 8'(STALE_LIMIT);

    logic [2:0]        cnt;
    logic [2:0]        cnt_limit;
    logic              tick;
    logic              legal;
    logic [2:0]        upd;
    logic [DATA_W-1:0] ch_q [3];
    logic [2:0]        strobe_q;
    logic              tick_q;
    logic [7:0]        stale_cnt [3];
    logic [7:0]        err_q;
    logic [2:0]        stale_flags;

    // Tick when the count reaches period-1; ">=" so a shrunk dwell ticks at once.
    always_comb begin
        cnt_limit = (bus.dwell <= 3'd1) ? 3'd0 : bus.dwell - 3'd1;
        tick      = bus.en && (cnt >= cnt_limit);
        legal     = (bus.mode <= 3'd2);
        upd       = 3'b000;
        if (tick && legal) begin
            upd = 3'b001 << bus.mode[1:0];
        end
    end

    // Dwell counter: clears on tick, advances while enabled, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if (tick) begin
            cnt <= 3'd0;
        end else if (bus.en) begin
            cnt <= cnt + 3'd1;
        end
    end

    // Channel holding registers plus the registered strobe and tick pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) ch_q[i] <= '0;
            strobe_q <= 3'b000;
            tick_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (upd[i]) ch_q[i] <= bus.din;
            end
            strobe_q <= upd;
            tick_q   <= tick;
        end
    end

    // Per-channel staleness: clear on update, otherwise count ticks up to the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) stale_cnt[i] <= LIMIT;
        end else if (tick) begin
            for (int i = 0; i < 3; i++) begin
                if (upd[i]) begin
                    stale_cnt[i] <= 8'd0;
                end else if (stale_cnt[i] < LIMIT) begin
                    stale_cnt[i] <= stale_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Saturating count of samples carrying an illegal mode tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 8'd0;
        end else if (tick && !legal && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    // Stale flags decode straight from the registered counters.
    always_comb begin
        stale_flags = 3'b000;
        for (int i = 0; i < 3; i++) begin
            stale_flags[i] = (stale_cnt[i] == LIMIT);
        end
    end

    assign bus.ch0_out     = ch_q[0];
    assign bus.ch1_out     = ch_q[1];
    assign bus.ch2_out     = ch_q[2];
    assign bus.ch_strobe   = strobe_q;
    assign bus.sample_tick = tick_q;
    assign bus.ch_stale    = stale_flags;
    assign bus.err_count   = err_q;
endmodule

// File: tb/tb_tdm_stream_demux.sv
// Directed bench for tdm_stream_demux: reset, round-robin routing, staleness,
// illegal-tag saturation, enable pause, dwell shrink and mid-run reset.
module tb_tdm_stream_demux;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tdm_stream_demux_if #(.DATA_W(8)) bus ();

    tdm_stream_demux #(.DATA_W(8), .STALE_LIMIT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change right after a falling edge; outputs are read at the next one.
    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [7:0] ch_out(input int c);
        case (c)
            0:       return bus.ch0_out;
            1:       return bus.ch1_out;
            default: return bus.ch2_out;
        endcase
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ch0"}, 32'(bus.ch0_out), 32'h00);
        chk({tag, "_ch1"}, 32'(bus.ch1_out), 32'h00);
        chk({tag, "_ch2"}, 32'(bus.ch2_out), 32'h00);
        chk({tag, "_strobe"}, 32'(bus.ch_strobe), 32'h0);
        chk({tag, "_tick"}, 32'(bus.sample_tick), 32'h0);
        chk({tag, "_err"}, 32'(bus.err_count), 32'h00);
        chk({tag, "_stale"}, 32'(bus.ch_stale), 32'h7);
    endtask

    logic [7:0] rr_data [3];
    logic [2:0] rr_stale [3];

    initial begin
        rr_data[0] = 8'hA1; rr_data[1] = 8'hB2; rr_data[2] = 8'hC3;
        rr_stale[0] = 3'b110; rr_stale[1] = 3'b100; rr_stale[2] = 3'b000;

        rst = 1'b1;
        bus.en = 1'b0; bus.dwell = 3'd0; bus.mode = 3'd0; bus.din = 8'h00;
        repeat (3) step();
        chk_reset_state("rst_init");
        rst = 1'b0;

        // Round-robin, dwell 4: each channel ticks on the 4th edge of its window.
        bus.dwell = 3'd4; bus.en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.mode = 3'(c); bus.din = rr_data[c];
            repeat (3) begin
                step();
                chk("rr_idle_tick", 32'(bus.sample_tick), 32'h0);
                chk("rr_idle_strobe", 32'(bus.ch_strobe), 32'h0);
            end
            step();
            chk("rr_tick", 32'(bus.sample_tick), 32'h1);
            chk("rr_strobe", 32'(bus.ch_strobe), 32'(3'b001 << c));
            chk("rr_data", 32'(ch_out(c)), 32'(rr_data[c]));
            chk("rr_stale", 32'(bus.ch_stale), 32'(rr_stale[c]));
        end

        // Stale detection, dwell 2: one ch0 update then 15 ch1-only ticks.
        bus.dwell = 3'd2; bus.mode = 3'd0; bus.din = 8'h11;
        step();
        chk("st_idle_tick", 32'(bus.sample_tick), 32'h0);
        step();
        chk("st_ch0_strobe", 32'(bus.ch_strobe), 32'h1);
        chk("st_ch0_fresh", 32'(bus.ch_stale[0]), 32'h0);
        bus.mode = 3'd1; bus.din = 8'h22;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("st_gap_tick", 32'(bus.sample_tick), 32'h0);
            step();
            chk("st_ch1_strobe", 32'(bus.ch_strobe), 32'h2);
            chk("st_ch0_stale", 32'(bus.ch_stale[0]), (k == 15) ? 32'h1 : 32'h0);
        end
        chk("st_all_stale", 32'(bus.ch_stale), 32'h5);
        bus.mode = 3'd0; bus.din = 8'h33;
        step();
        step();
        chk("st_clear_strobe", 32'(bus.ch_strobe), 32'h1);
        chk("st_clear_stale", 32'(bus.ch_stale), 32'h4);
        chk("st_clear_ch0", 32'(bus.ch0_out), 32'h33);

        // Illegal tags every cycle: err_count saturates at 255.
        bus.dwell = 3'd1; bus.mode = 3'd7; bus.din = 8'hEE;
        for (int k = 1; k <= 300; k++) begin
            step();
            chk("ill_tick", 32'(bus.sample_tick), 32'h1);
            chk("ill_strobe", 32'(bus.ch_strobe), 32'h0);
            chk("ill_err", 32'(bus.err_count), (k < 255) ? 32'(k) : 32'd255);
        end
        chk("ill_ch0", 32'(bus.ch0_out), 32'h33);
        chk("ill_ch1", 32'(bus.ch1_out), 32'h22);
        chk("ill_ch2", 32'(bus.ch2_out), 32'hC3);
        chk("ill_stale", 32'(bus.ch_stale), 32'h7);

        // Enable pause, dwell 5: 3 enabled edges, 10 paused, tick 2 edges later.
        bus.dwell = 3'd5; bus.mode = 3'd2; bus.din = 8'h44;
        repeat (3) begin
            step();
            chk("pa_pre_tick", 32'(bus.sample_tick), 32'h0);
        end
        bus.en = 1'b0;
        repeat (10) begin
            step();
            chk("pa_hold_tick", 32'(bus.sample_tick), 32'h0);
            chk("pa_hold_ch2", 32'(bus.ch2_out), 32'hC3);
        end
        bus.en = 1'b1;
        step();
        chk("pa_resume1_tick", 32'(bus.sample_tick), 32'h0);
        step();
        chk("pa_resume2_tick", 32'(bus.sample_tick), 32'h1);
        chk("pa_strobe", 32'(bus.ch_strobe), 32'h4);
        chk("pa_ch2", 32'(bus.ch2_out), 32'h44);
        chk("pa_stale", 32'(bus.ch_stale), 32'h3);

        // Dwell shrink: 7 -> 2 with cnt at 5 ticks on the very next edge.
        bus.dwell = 3'd7; bus.mode = 3'd0; bus.din = 8'h55;
        repeat (5) begin
            step();
            chk("sh_pre_tick", 32'(bus.sample_tick), 32'h0);
        end
        bus.dwell = 3'd2;
        step();
        chk("sh_first_tick", 32'(bus.sample_tick), 32'h1);
        chk("sh_first_ch0", 32'(bus.ch0_out), 32'h55);
        bus.din = 8'h56;
        step();
        chk("sh_gap1_tick", 32'(bus.sample_tick), 32'h0);
        step();
        chk("sh_second_tick", 32'(bus.sample_tick), 32'h1);
        chk("sh_second_ch0", 32'(bus.ch0_out), 32'h56);
        step();
        chk("sh_gap2_tick", 32'(bus.sample_tick), 32'h0);
        step();
        chk("sh_third_tick", 32'(bus.sample_tick), 32'h1);

        // Reset mid-count with en high; asynchronous, then first tick on 3rd edge.
        bus.dwell = 3'd7; bus.mode = 3'd1; bus.din = 8'h77;
        repeat (3) step();
        #2 rst = 1'b1;
        #1 chk_reset_state("rst_async");
        step();
        chk_reset_state("rst_mid");
        rst = 1'b0;
        bus.dwell = 3'd3; bus.mode = 3'd1; bus.din = 8'h66;
        step();
        chk("rel_edge1_tick", 32'(bus.sample_tick), 32'h0);
        step();
        chk("rel_edge2_tick", 32'(bus.sample_tick), 32'h0);
        step();
        chk("rel_edge3_tick", 32'(bus.sample_tick), 32'h1);
        chk("rel_strobe", 32'(bus.ch_strobe), 32'h2);
        chk("rel_ch1", 32'(bus.ch1_out), 32'h66);
        chk("rel_stale", 32'(bus.ch_stale), 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
